// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point adder/subtractor.
// Operands are packed {sign, exponent, fraction}. A zero exponent means
// exact zero, and the largest exponent is an ordinary value on input.
// A started operation walks through ALIGN, ADD, NORM and ROUND. Each state
// advances one step per enabled clock.
//
// Build option: define FPADD_RNE_EN for round-to-nearest-even. Without it,
// the guard/round/sticky bits are discarded (truncation). Both builds have
// the same ROUND state and the same latency.
//
// Handshake (en gates every edge):
//   - load is sampled on an enabled edge while the FSM is in IDLE, or in
//     DONE on the edge that leaves DONE. In any other state it is ignored;
//     nothing is queued.
//   - busy goes high on the accepting edge. It stays high until the edge
//     that leaves DONE.
//   - done is high for exactly the one enabled cycle spent in DONE. While
//     done is high, result and ovf are valid.
//   - result and ovf hold their values until the next done.
//   - dbg_state exposes the FSM state register.

module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [2:0]   dbg_state
);

  // Working mantissa layout: carry | hidden | fraction | guard round sticky.
  localparam int MW = MAN_W + 5;
  // Exponent carries one extra bit so ADD and ROUND carries cannot wrap.
  localparam int XW = EXP_W + 1;
  localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic             esub_q, esub_d;
  logic [XW-1:0]    exp_q, exp_d;
  logic [MW-1:0]    mx_q, mx_d;
  logic [MW-1:0]    my_q, my_d;
  logic [EXP_W-1:0] d_q, d_d;
  logic [W-1:0]     result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             take;

  // Operand unpacking and magnitude ordering.
  logic             sa, sb_eff, a_ge_b;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    ma, mb;

  // Datapath intermediates for ADD and ROUND.
  logic [MW-1:0]    sum;
  logic             inc;
  logic [MAN_W+1:0] rnd;
  logic [XW-1:0]    exp_r;
  logic [MAN_W-1:0] frac_r;

  // Unpack operands. Zero exponent drops the hidden bit and the fraction.
  always_comb begin : unpack_ops
    sa     = a[W-1];
    ea     = a[W-2:MAN_W];
    fa     = a[MAN_W-1:0];
    sb_eff = b[W-1] ^ sub;
    eb     = b[W-2:MAN_W];
    fb     = b[MAN_W-1:0];
    a_ge_b = ({ea, fa} >= {eb, fb});
    ma     = (ea != '0) ? {1'b0, 1'b1, fa, 3'b000} : '0;
    mb     = (eb != '0) ? {1'b0, 1'b1, fb, 3'b000} : '0;
  end

`ifdef FPADD_RNE_EN
  // Round up when guard is set and the value is above half, or exactly half with odd LSB.
  assign inc = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
`else
  // Truncation: guard/round/sticky never contribute.
  assign inc = 1'b0;
`endif

  // Add/subtract and rounding arithmetic.
  always_comb begin : datapath
    sum    = esub_q ? (mx_q - my_q) : (mx_q + my_q);
    rnd    = {1'b0, mx_q[MW-2:3]} + {{(MAN_W+1){1'b0}}, inc};
    exp_r  = exp_q;
    frac_r = rnd[MAN_W-1:0];
    if (rnd[MAN_W+1]) begin
      exp_r  = exp_q + XW'(1);
      frac_r = rnd[MAN_W:1];
    end
  end

  // Next-state and register-input logic for the operation FSM.
  always_comb begin : next_state_logic
    state_d  = state_q;
    sign_d   = sign_q;
    esub_d   = esub_q;
    exp_d    = exp_q;
    mx_d     = mx_q;
    my_d     = my_q;
    d_d      = d_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    busy_d   = busy_q;
    take     = 1'b0;

    case (state_q)
      S_IDLE: begin
        take = load;
      end

      S_ALIGN: begin
        if (d_q == '0) begin
          state_d = S_ADD;
        end else if (32'(d_q) > MAN_W + 3) begin
          // Y lies entirely below the sticky position and folds into one bit.
          my_d = {{(MW-1){1'b0}}, |my_q};
          d_d  = '0;
        end else begin
          my_d = {1'b0, my_q[MW-1:1]} | {{(MW-1){1'b0}}, my_q[0]};
          d_d  = d_q - EXP_W'(1);
        end
      end

      S_ADD: begin
        // X >= Y by construction, so the difference never goes negative.
        if (sum[MW-1]) begin
          mx_d  = {1'b0, sum[MW-1:1]} | {{(MW-1){1'b0}}, sum[0]};
          exp_d = exp_q + XW'(1);
        end else begin
          mx_d = sum;
        end
        state_d = S_NORM;
      end

      S_NORM: begin
        if (mx_q == '0) begin
          // Both-zero and exact cancellation both give +0.
          result_d = '0;
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else if (!mx_q[MW-2]) begin
          if (exp_q <= XW'(1)) begin
            // Another shift would underflow; flush to +0.
            result_d = '0;
            ovf_d    = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            mx_d  = mx_q << 1;
            exp_d = exp_q - XW'(1);
          end
        end else begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        if (exp_r >= EXP_MAX) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
          ovf_d    = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        take    = load;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accept a new operation: the larger magnitude becomes X (ties pick a).
    if (take) begin
      state_d = S_ALIGN;
      busy_d  = 1'b1;
      esub_d  = sa ^ sb_eff;
      if (a_ge_b) begin
        sign_d = sa;
        exp_d  = {1'b0, ea};
        mx_d   = ma;
        my_d   = mb;
        d_d    = ea - eb;
      end else begin
        sign_d = sb_eff;
        exp_d  = {1'b0, eb};
        mx_d   = mb;
        my_d   = ma;
        d_d    = eb - ea;
      end
    end
  end

  // State and datapath registers; en low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      esub_q   <= 1'b0;
      exp_q    <= '0;
      mx_q     <= '0;
      my_q     <= '0;
      d_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (en) begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      esub_q   <= esub_d;
      exp_q    <= exp_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      d_q      <= d_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign result    = result_q;
  assign ovf       = ovf_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: directed cases plus random operands, checked
// against an arbitrary-precision-style reference (integer + sticky) model.

module tb_fp_addsub_seq;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         ovf;
  logic [2:0]   dbg_state;

  int tests = 0;
  int failed = 0;
  logic [W-1:0] exp_q[$];

  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: exact sum as integer (X scaled by 2^32) plus a flag for a
  // nonzero fraction below the integer grid, then normalise and round.
  function automatic void ref_model(input logic [31:0] av, input logic [31:0] bv, input logic s,
                                    output logic [31:0] res, output logic ov,
                                    output int lat, output logic zr);
    logic sa, sb, sx, sy, fl, up;
    int ea, eb, ex, ey, d, p, k, e, sh;
    longint unsigned ma, mb, mx, my, big_x, big_y, v, mant, rem, half;
    sa = av[31];
    sb = bv[31] ^ s;
    ea = int'(av[30:23]);
    eb = int'(bv[30:23]);
    ma = (ea == 0) ? 64'd0 : ((64'd1 << 23) | 64'(av[22:0]));
    mb = (eb == 0) ? 64'd0 : ((64'd1 << 23) | 64'(bv[22:0]));
    if (av[30:0] >= bv[30:0]) begin
      ex = ea; ey = eb; mx = ma; my = mb; sx = sa; sy = sb;
    end else begin
      ex = eb; ey = ea; mx = mb; my = ma; sx = sb; sy = sa;
    end
    d = ex - ey;
    big_x = mx << 32;
    fl = 1'b0;
    if (d <= 32) begin
      big_y = my << (32 - d);
    end else if (d - 32 >= 24) begin
      big_y = 64'd0;
      fl = (my != 64'd0);
    end else begin
      big_y = my >> (d - 32);
      fl = ((my & ((64'd1 << (d - 32)) - 64'd1)) != 64'd0);
    end
    if (sx == sy) v = big_x + big_y;
    else          v = big_x - big_y - (fl ? 64'd1 : 64'd0);
    res = '0; ov = 1'b0; lat = 0; zr = 1'b1;
    if (v == 64'd0) return;
    p = 0;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    e = ex + p - 55;
    if (e <= 0) return;
    zr = 1'b0;
    k = (p < 55) ? 55 - p : 0;
    sh = p - 23;
    mant = v >> sh;
    rem = v & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
`ifdef FPADD_RNE_EN
    up = (rem > half) || ((rem == half) && (fl || mant[0]));
`else
    up = 1'b0;
`endif
    mant = mant + (up ? 64'd1 : 64'd0);
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      res = {sx, 8'hFF, 23'd0};
      ov = 1'b1;
    end else begin
      res = {sx, 8'(e), mant[22:0]};
      ov = 1'b0;
    end
    lat = ((d > 26) ? 1 : d) + k + 4;
  endfunction

  // Driver: pulse load, then count enabled cycles until done (-1 on timeout).
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        output logic [31:0] res, output logic ov, output int lat);
    @(negedge clk);
    a = av; b = bv; sub = s; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    lat = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    ov = ovf;
    if (!done) lat = -1;
  endtask

  initial begin
    logic [31:0] res, eres, av, bv;
    logic ov, eov, ez, s;
    int lat, elat, n, ndone, ea_i, eb_i, mode;
    logic [2:0] st;

    // Reset state.
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b1;

    // 1.0 + 1.0
    run_op(32'h3F800000, 32'h3F800000, 1'b0, res, ov, lat);
    check("one_plus_one", res, 32'h40000000);
    check("one_plus_one_ovf", ov, 0);
    check("one_plus_one_lat", lat, 4);

    // 1.5 - 1.5 cancels to +0
    run_op(32'h3FC00000, 32'h3FC00000, 1'b1, res, ov, lat);
    check("cancel_res", res, 32'h00000000);
    check("cancel_ovf", ov, 0);
    check("cancel_done_seen", (lat >= 0), 1);

    // d = 24 alignment with rounding bits
    run_op(32'h3F800000, 32'h33C00000, 1'b0, res, ov, lat);
`ifdef FPADD_RNE_EN
    check("align24_res", res, 32'h3F800001);
`else
    check("align24_res", res, 32'h3F800000);
`endif
    check("align24_lat", lat, 28);

    // 24 normalisation shifts
    run_op(32'h3F800000, 32'h3F7FFFFF, 1'b1, res, ov, lat);
    check("norm24_res", res, 32'h33800000);
    check("norm24_lat", lat, 29);

    // Exponent overflow
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, res, ov, lat);
    check("ovf_res", res, 32'h7F800000);
    check("ovf_flag", ov, 1);
    @(negedge clk);
    check("ovf_done_falls", done, 0);
    check("ovf_busy_falls", busy, 0);

    // load while busy is ignored
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("busy_after_load", busy, 1);
    @(negedge clk);
    a = 32'h40400000; b = 32'h3F800000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ignore_load_res", result, 32'h40000000);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignore_load_no_second", ndone, 0);
    check("ignore_load_idle", busy, 0);

    // en low three cycles mid-ALIGN delays done by three
    @(negedge clk);
    a = 32'h3F800000; b = 32'h33C00000; sub = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    st = '0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        en = 1'b0;
        st = dbg_state;
      end
      if (n == 8) begin
        check("en_freeze_state", dbg_state, st);
        en = 1'b1;
      end
    end
    check("en_stall_lat", n, 31);
    en = 1'b0;
    @(negedge clk);
    check("done_held_en_low", done, 1);
    en = 1'b1;
    @(negedge clk);
    check("done_drop_en_high", done, 0);

    // Reset during NORM aborts with no done
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F7FFFFF; sub = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // Recovery after abort
    run_op(32'h40000000, 32'h3F800000, 1'b0, res, ov, lat);
    check("recover_res", res, 32'h40400000);
    check("recover_lat", lat, 5);

    // Randomised operands against the reference model
    for (int i = 0; i < 80; i++) begin
      mode = $urandom_range(0, 3);
      ea_i = $urandom_range(1, 254);
      case (mode)
        0: eb_i = $urandom_range(0, 254);
        1: eb_i = ea_i - $urandom_range(0, 3);
        2: eb_i = ea_i - $urandom_range(20, 40);
        default: eb_i = ea_i;
      endcase
      if (eb_i < 0) eb_i = 0;
      av = {1'($urandom_range(0, 1)), 8'(ea_i), 23'($urandom)};
      bv = {1'($urandom_range(0, 1)), 8'(eb_i), 23'($urandom)};
      if (mode == 3) bv[22:0] = av[22:0] ^ 23'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) av[30:23] = 8'd0;
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] tmp;
        tmp = av; av = bv; bv = tmp;
      end
      s = 1'($urandom_range(0, 1));
      ref_model(av, bv, s, eres, eov, elat, ez);
      exp_q.push_back(eres);
      run_op(av, bv, s, res, ov, lat);
      check("rand_done_seen", (lat >= 0), 1);
      check("rand_res", res, exp_q.pop_front());
      check("rand_ovf", ov, eov);
      if (!ez) check("rand_lat", lat, elat);
      @(negedge clk);
      check("rand_busy_clear", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
